// File: rtl/sub_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sub_pipe : pipelined WIDTH-bit subtractor, one 4-bit borrow-lookahead slice
// per stage. Optional macro SUB_PIPE_SAT_EN saturates diff on signed overflow.
// Rev 1.0
// ----------------------------------------------------------------------------
module sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minu,
  input  logic [WIDTH-1:0] subt,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int NIB = WIDTH / 4;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Returns {borrow_out, diff[3:0]} for one nibble.
  function automatic logic [4:0] nib_sub(input logic [3:0] a, input logic [3:0] b,
                                         input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ~a & b;
    p    = ~(a ^ b);
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

  generate
    for (genvar k = 0; k < NIB; k++) begin : g_stage
      // Stage k sees operand bits [WIDTH-1:4k]; bits above its nibble move on skewed.
      localparam int SW = WIDTH - 4 * k;
      logic [SW-1:0]  src_a;
      logic [SW-1:0]  src_b;
      logic           src_c;
      logic           v_in;
      logic [4:0]     nib;
      logic [4*k+3:0] raw;
      logic [4*k+3:0] res_in;
      logic [4*k+3:0] res;
      logic           v;
      logic           bo;

      assign nib = nib_sub(src_a[3:0], src_b[3:0], src_c);

      if (k == 0) begin : g_first
        assign src_a = minu;
        assign src_b = subt;
        assign src_c = borrow_in;
        assign v_in  = in_valid;
        assign raw   = nib[3:0];
      end else begin : g_next
        assign src_a = g_stage[k-1].g_skew.hi_a;
        assign src_b = g_stage[k-1].g_skew.hi_b;
        assign src_c = g_stage[k-1].bo;
        assign v_in  = g_stage[k-1].v;
        assign raw   = {nib[3:0], g_stage[k-1].res};
      end

      if (k < NIB - 1) begin : g_skew
        logic [SW-5:0] hi_a;
        logic [SW-5:0] hi_b;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            hi_a <= '0;
            hi_b <= '0;
          end else if (adv) begin
            hi_a <= src_a[SW-1:4];
            hi_b <= src_b[SW-1:4];
          end
        end
      end

      if (k == NIB - 1) begin : g_last
        logic ovf_in;
        logic ov;
        assign ovf_in = (src_a[SW-1] ^ src_b[SW-1]) & (nib[3] ^ src_a[SW-1]);
`ifdef SUB_PIPE_SAT_EN
        assign res_in = ovf_in ? {src_a[SW-1], {(4*k+3){~src_a[SW-1]}}} : raw;
`else
        assign res_in = raw;
`endif
        always_ff @(posedge clk or posedge rst) begin
          if (rst)      ov <= 1'b0;
          else if (adv) ov <= ovf_in;
        end
      end else begin : g_mid
        assign res_in = raw;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v   <= 1'b0;
          bo  <= 1'b0;
          res <= '0;
        end else if (adv) begin
          v   <= v_in;
          bo  <= nib[4];
          res <= res_in;
        end
      end
    end
  endgenerate

  assign out_valid  = g_stage[NIB-1].v;
  assign diff       = g_stage[NIB-1].res;
  assign borrow_out = g_stage[NIB-1].bo;
  assign overflow   = g_stage[NIB-1].g_last.ov;

endmodule
`default_nettype wire

// File: tb/tb_sub_pipe.sv
`default_nettype none
// tb_sub_pipe : directed vectors with hand-computed results, scoreboard + monitor.
module tb_sub_pipe;
  localparam int WIDTH = 16;
  localparam int NIB   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] minu = '0;
  logic [WIDTH-1:0] subt = '0;
  logic             borrow_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sub_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .minu(minu), .subt(subt), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] s;
    logic        b;
    logic [15:0] d;   // wrapped difference
    logic        bo;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  vec_t vt [17];
  exp_t q [$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic send(input int i, input bit push, input bit lat);
    exp_t e;
    bit   done;
    done      = 1'b0;
    minu      = vt[i].m;
    subt      = vt[i].s;
    borrow_in = vt[i].b;
    in_valid  = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          e.d = vt[i].d;
`ifdef SUB_PIPE_SAT_EN
          if (vt[i].ov) e.d = vt[i].m[15] ? 16'h8000 : 16'h7FFF;
`endif
          e.bo  = vt[i].bo;
          e.ov  = vt[i].ov;
          e.acc = cyc;
          e.lat = lat;
          q.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout vector=%0d actual=not_accepted required=accepted", i);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=no_output", diff);
      end else begin
        mon_e = q.pop_front();
        chk("diff", 32'(diff), 32'(mon_e.d));
        chk("borrow_out", 32'(borrow_out), 32'(mon_e.bo));
        chk("overflow", 32'(overflow), 32'(mon_e.ov));
        if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'(NIB));
      end
    end
  end

  initial begin
    vt[0]  = {16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[1]  = {16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2]  = {16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3]  = {16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[4]  = {16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vt[5]  = {16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vt[6]  = {16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0};
    vt[7]  = {16'h00F0, 16'h0F00, 1'b0, 16'hF1F0, 1'b1, 1'b0};
    vt[8]  = {16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
    vt[9]  = {16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1, 1'b1};
    vt[10] = {16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
    vt[11] = {16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[12] = {16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vt[13] = {16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};
    vt[14] = {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[15] = {16'hC000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0};
    vt[16] = {16'h4000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow_out", 32'(borrow_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream: three in-flight ops must vanish
    for (int i = 0; i < 3; i++) send(i, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed: basic, borrow chains, signed overflow
    for (int i = 0; i < 5; i++) send(i, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back run of eight
    for (int i = 5; i < 13; i++) send(i, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Fill pipeline, then hold out_ready low for 5 cycles
    for (int i = 13; i < 17; i++) send(i, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_diff", 32'(diff), 32'(vt[13].d));
      chk("stall_borrow_out", 32'(borrow_out), 32'(vt[13].bo));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sub_pipe.md
Name: sub_pipe

Overview:
Pipelined N-bit subtractor computing diff = minu - subt - borrow_in, with borrow-out and signed-overflow flags. It is the subtract-direction counterpart of the nibble carry-lookahead adder used in the CORDIC datapath. The datapath is split into 4-bit borrow-lookahead slices, with one register stage per slice so the borrow ripples between slices across clock edges. Valid/ready handshake on both sides; one result per cycle when not stalled.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
NIB, WIDTH/4, number of 4-bit slices and pipeline stages (derived; not overridable).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid this cycle
in_ready  output  1  block accepts operands this cycle
minu  input  WIDTH  minuend, two's complement
subt  input  WIDTH  subtrahend, two's complement
borrow_in  input  1  borrow into bit 0
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
diff  output  WIDTH  minu - subt - borrow_in, modulo 2^WIDTH
borrow_out  output  1  1 when unsigned minu < subt + borrow_in
overflow  output  1  signed overflow of the subtraction

Behaviour:
- Reset (async, rst=1): all pipeline valid bits, skew registers, partial results and borrow registers cleared; out_valid=0, diff=0, borrow_out=0, overflow=0. Any in-flight operations are discarded and never produced. Deassertion takes effect from the next rising edge.
- Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational).
- Accept: a transfer occurs when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Stage k (0..NIB-1): 4-bit borrow-lookahead on nibble k, using generate g = ~a & b and propagate p = ~(a ^ b). The borrow input is borrow_in for k=0; for k>0 it is the registered borrow from stage k-1. Nibble k of each operand is delayed k cycles through skew registers. Completed lower nibbles are delayed so all nibbles align at the output.
- Latency: exactly NIB cycles from acceptance to out_valid when not stalled (WIDTH=16: 4 cycles). Throughput: 1 per cycle.
- Stall: when adv=0, every pipeline register holds its value and diff/borrow_out/overflow are stable. Results are never dropped or duplicated.
- Flags: borrow_out is the borrow out of the top slice. overflow = (minu[MSB] ^ subt[MSB]) & (diff[MSB] ^ minu[MSB]), computed from the aligned, registered MSBs.
- Outputs are registered. No combinational path from minu/subt to diff.
- Simultaneous accept and output consume in the same cycle is allowed (full rate).

Optional Feature:
SUB_PIPE_SAT_EN: when defined, if overflow=1 then diff is forced to signed saturation: 0x7FF..F if minu is non-negative, 0x800..0 if minu is negative. borrow_out and overflow are still reported unchanged. When undefined, diff wraps modulo 2^WIDTH. Saturation is applied in the final stage, so latency is unchanged.

Test Plan:
- Reset mid-stream: issue 3 ops, assert rst for 1 cycle before any output -> out_valid stays 0, no stale results afterward, in_ready=1 after release.
- Basic: minu=0x1234, subt=0x0234, borrow_in=0 -> after 4 cycles diff=0x1000, borrow_out=0, overflow=0.
- Borrow chain across all slices: minu=0x0000, subt=0x0001 -> diff=0xFFFF, borrow_out=1, overflow=0. minu=0x0000, subt=0x0000, borrow_in=1 -> diff=0xFFFF, borrow_out=1.
- Signed overflow: minu=0x8000, subt=0x0001 -> diff=0x7FFF, overflow=1 (with SUB_PIPE_SAT_EN: diff=0x8000). minu=0x7FFF, subt=0xFFFF -> diff=0x8000, overflow=1 (with SAT: 0x7FFF).
- Back-to-back: 8 consecutive random ops with out_ready=1 -> 8 results in order on consecutive cycles, first at cycle 4, matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0 and outputs frozen. After release, all results arrive in order with no loss or duplication.
